// File: rtl/roll_channel_select.sv
// roll_channel_select
//   Selects one of NCH sample streams for the display path. In roll mode, the
//   stream is decimated by a programmable factor. The result is presented
//   through a single-entry registered valid/ready output.
//   Channel, roll and decimation settings are latched only on frame_start.
//   This keeps a frame from ever mixing channels or decimation phases.
//
//   Optional feature macro: ROLL_SEL_OVF_CNT_EN
//     defined   - ovf_count is a saturating count of dropped samples
//     undefined - ovf_count is tied to zero (drops still happen)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_data      NCH packed samples, channel k at [k*WIDTH +: WIDTH]
//   in_valid     per-channel sample strobe, no upstream backpressure
//   sel          requested channel (ignored if >= NCH)
//   roll_mode    requested mode, 1 = decimate
//   decim        decimation factor, 0 behaves as 1
//   frame_start  one-cycle frame boundary pulse
//   out_data     selected sample
//   out_ch       channel the sample came from
//   out_valid    output holds a sample
//   out_ready    display accepts on out_valid & out_ready
//   ovf_count    dropped-sample counter
module roll_channel_select #(
  parameter int WIDTH   = 12,
  parameter int NCH     = 4,
  parameter int DECIM_W = 16,
  parameter int SELW    = $clog2(NCH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   in_data,
  input  logic [NCH-1:0]         in_valid,
  input  logic [SELW-1:0]        sel,
  input  logic                   roll_mode,
  input  logic [DECIM_W-1:0]     decim,
  input  logic                   frame_start,
  output logic [WIDTH-1:0]       out_data,
  output logic [SELW-1:0]        out_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            ovf_count
);

  // One extra bit so that sel can be compared against NCH
  // even when NCH is a power of two.
  localparam logic [SELW:0] NCH_V = (SELW+1)'(NCH);

  logic [SELW-1:0]    act_ch;
  logic               act_roll;
  logic [DECIM_W-1:0] act_decim;   // already clamped to >= 1
  logic [DECIM_W-1:0] dcnt;

  logic               ch_valid;
  logic [WIDTH-1:0]   ch_data;
  logic               fwd;
  logic               sel_ok;

  assign sel_ok   = ({1'b0, sel} < NCH_V);
  assign ch_valid = in_valid[act_ch];
  assign ch_data  = in_data[act_ch*WIDTH +: WIDTH];
  assign fwd      = ch_valid & (~act_roll | (dcnt == '0));

  // The new settings take effect from the cycle after frame_start.
  // A sample arriving in the frame_start cycle still uses the old settings.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_ch    <= '0;
      act_roll  <= 1'b0;
      act_decim <= DECIM_W'(1);
    end else if (frame_start) begin
      if (sel_ok) act_ch <= sel;
      act_roll  <= roll_mode;
      act_decim <= (decim == '0) ? DECIM_W'(1) : decim;
    end
  end

  // The decimation phase restarts at every frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= '0;
    end else if (frame_start || !act_roll) begin
      dcnt <= '0;
    end else if (ch_valid) begin
      dcnt <= (dcnt >= act_decim - DECIM_W'(1)) ? '0 : dcnt + DECIM_W'(1);
    end
  end

  // Single-entry output register.
  // A forwarded sample that finds the slot full and not being accepted is
  // dropped, and the held sample is left untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else if (fwd && (!out_valid || out_ready)) begin
      out_data  <= ch_data;
      out_ch    <= act_ch;
      out_valid <= 1'b1;
    end else if (!fwd && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ROLL_SEL_OVF_CNT_EN
  logic drop;
  assign drop = fwd & out_valid & ~out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if (drop && (ovf_count != 16'hFFFF)) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`else
  assign ovf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_roll_channel_select.sv
module tb_roll_channel_select;

  localparam int WIDTH = 12;
  localparam int NCH   = 4;

`ifdef ROLL_SEL_OVF_CNT_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [1:0]           sel;
  logic                 roll_mode;
  logic [15:0]          decim;
  logic                 frame_start;
  logic [WIDTH-1:0]     out_data;
  logic [1:0]           out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic [15:0]          ovf_count;

  // This second instance has NCH=3, so that an out-of-range sel value
  // can be represented on the sel port.
  logic [3*WIDTH-1:0]   in_data3;
  logic [2:0]           in_valid3;
  logic [1:0]           sel3;
  logic                 roll3;
  logic [15:0]          decim3;
  logic                 fs3;
  logic [WIDTH-1:0]     out_data3;
  logic [1:0]           out_ch3;
  logic                 out_valid3;
  logic                 ready3;
  logic [15:0]          ovf3;

  always #5 clk = ~clk;

  roll_channel_select #(.WIDTH(WIDTH), .NCH(NCH), .DECIM_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .sel(sel), .roll_mode(roll_mode), .decim(decim), .frame_start(frame_start),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready), .ovf_count(ovf_count)
  );

  roll_channel_select #(.WIDTH(WIDTH), .NCH(3), .DECIM_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .sel(sel3), .roll_mode(roll3), .decim(decim3), .frame_start(fs3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(ready3), .ovf_count(ovf3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fs;
    logic [1:0]  sel;
    logic        roll;
    logic [15:0] decim;
    logic [3:0]  vld;
    logic [11:0] d;
    logic        rdy;
    logic        ev;
    logic [11:0] ed;
    logic [1:0]  ech;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic fs, input logic [1:0] s, input logic r,
                     input logic [15:0] dc, input logic [3:0] v, input logic [11:0] d,
                     input logic rdy, input logic ev, input logic [11:0] ed,
                     input logic [1:0] ech);
    vec_t t;
    t.fs = fs; t.sel = s; t.roll = r; t.decim = dc; t.vld = v; t.d = d;
    t.rdy = rdy; t.ev = ev; t.ed = ed; t.ech = ech;
    tbl.push_back(t);
  endtask

  // ---------------- behavioural reference model ----------------
  // k counts active-channel samples since the last frame boundary.
  // In roll mode, a sample is kept when k is a multiple of the factor.
  int m_ch, m_roll, m_decim, m_k, m_v, m_d, m_c, m_ovf;

  task automatic m_reset();
    m_ch = 0; m_roll = 0; m_decim = 1; m_k = 0;
    m_v = 0; m_d = 0; m_c = 0; m_ovf = 0;
  endtask

  task automatic m_step();
    int  deff;
    bit  cv, fwd;
    deff = (m_decim == 0) ? 1 : m_decim;
    cv   = in_valid[m_ch];
    fwd  = cv && (m_roll == 0 || (m_k % deff) == 0);
    if (frame_start) m_k = 0;
    else if (cv && m_roll != 0) m_k++;
    if (fwd && (m_v == 0 || out_ready)) begin
      m_v = 1;
      m_d = int'(in_data[m_ch*WIDTH +: WIDTH]);
      m_c = m_ch;
    end else if (fwd) begin
      if (OVF_ON && m_ovf < 65535) m_ovf++;
    end else if (out_ready) begin
      m_v = 0;
    end
    if (frame_start) begin
      if (int'(sel) < NCH) m_ch = int'(sel);
      m_roll  = int'(roll_mode);
      m_decim = int'(decim);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_data = '0; in_valid = '0; sel = '0; roll_mode = 1'b0; decim = 16'd1;
    frame_start = 1'b0; out_ready = 1'b1;
    in_data3 = '0; in_valid3 = '0; sel3 = '0; roll3 = 1'b0; decim3 = 16'd1;
    fs3 = 1'b0; ready3 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data",  int'(out_data),  0);
    chk("rst_out_ch",    int'(out_ch),    0);
    chk("rst_ovf",       int'(ovf_count), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Select ch2 and pass every sample. Strobes on other channels are ignored.
    add(1, 2, 0, 1, 4'b0000, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 4'b0100, 12'h123, 1, 1, 12'h123, 2);
    add(0, 0, 0, 0, 4'b1011, 12'h055, 1, 0, 0, 0);
    add(0, 0, 0, 0, 4'b0001, 12'h056, 1, 0, 0, 0);
    // Decimate ch0 by 4: keep samples 0, 4 and 8.
    add(1, 0, 1, 4, 4'b0000, 12'h000, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      add(0, 0, 0, 0, 4'b0001, 12'(i), 1, (i % 4) == 0, 12'(i), 0);
    // A factor of 0 behaves as 1.
    add(1, 0, 1, 0, 4'b0000, 12'h000, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 4'b0001, 12'h020 + 12'(i), 1, 1, 12'h020 + 12'(i), 0);
    // Switch ch1 -> ch3 on a frame boundary that coincides with a ch1 sample.
    add(1, 1, 0, 1, 4'b0000, 12'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 4'b0010, 12'h0A0, 1, 1, 12'h0A0, 1);
    add(1, 3, 0, 1, 4'b0010, 12'h0AA, 1, 1, 12'h0AA, 1);
    add(0, 0, 0, 0, 4'b0010, 12'h0BB, 1, 0, 0, 0);
    add(0, 0, 0, 0, 4'b1000, 12'h0CC, 1, 1, 12'h0CC, 3);
    add(0, 0, 0, 0, 4'b1010, 12'h0CD, 1, 1, 12'h0CD, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      frame_start = tbl[i].fs; sel = tbl[i].sel; roll_mode = tbl[i].roll;
      decim = tbl[i].decim; in_valid = tbl[i].vld; in_data = {NCH{tbl[i].d}};
      out_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_data", i), int'(out_data), int'(tbl[i].ed));
        chk($sformatf("vec%0d_ch", i),   int'(out_ch),   int'(tbl[i].ech));
      end
    end
    frame_start = 1'b0; in_valid = '0;

    // Backpressure: B and C are dropped while A is held.
    frame_start = 1'b1; sel = 2'd0; roll_mode = 1'b0; decim = 16'd1; out_ready = 1'b1;
    cyc();
    frame_start = 1'b0; out_ready = 1'b0;
    in_valid = 4'b0001; in_data = {NCH{12'h0A1}};
    cyc(); chk("bp_A_valid", int'(out_valid), 1); chk("bp_A_data", int'(out_data), 'h0A1);
    in_data = {NCH{12'h0B2}};
    cyc(); chk("bp_B_hold", int'(out_data), 'h0A1);
    in_data = {NCH{12'h0C3}};
    cyc(); chk("bp_C_hold", int'(out_data), 'h0A1);
    in_valid = '0;
    cyc();
    chk("bp_valid_held", int'(out_valid), 1);
    chk("bp_data_held",  int'(out_data), 'h0A1);
    chk("bp_ch_held",    int'(out_ch), 0);
    chk("bp_ovf",        int'(ovf_count), OVF_ON ? 2 : 0);
    out_ready = 1'b1;
    cyc(); chk("bp_drain_valid", int'(out_valid), 0);

    // On the NCH=3 instance, sel=3 is out of range: the channel stays at 2,
    // while roll and decim still update.
    fs3 = 1'b1; sel3 = 2'd2; roll3 = 1'b0; decim3 = 16'd1;
    cyc(); fs3 = 1'b0;
    in_valid3 = 3'b100; in_data3 = {3{12'h210}};
    cyc(); chk("n3_valid", int'(out_valid3), 1); chk("n3_ch", int'(out_ch3), 2);
    chk("n3_data", int'(out_data3), 'h210);
    in_valid3 = '0; fs3 = 1'b1; sel3 = 2'd3; roll3 = 1'b1; decim3 = 16'd2;
    cyc(); fs3 = 1'b0; chk("n3_idle", int'(out_valid3), 0);
    in_valid3 = 3'b100; in_data3 = {3{12'h231}};
    cyc(); chk("n3_keep_valid", int'(out_valid3), 1); chk("n3_keep_ch", int'(out_ch3), 2);
    chk("n3_keep_data", int'(out_data3), 'h231);
    in_data3 = {3{12'h232}};
    cyc(); chk("n3_decim_skip", int'(out_valid3), 0);
    in_valid3 = 3'b001; in_data3 = {3{12'h233}};
    cyc(); chk("n3_ch0_ignored", int'(out_valid3), 0);
    in_valid3 = 3'b100; in_data3 = {3{12'h234}};
    cyc(); chk("n3_wrap_valid", int'(out_valid3), 1); chk("n3_wrap_data", int'(out_data3), 'h234);
    in_valid3 = '0;

    // Async reset mid-operation with a pending output.
    out_ready = 1'b0; in_valid = 4'b0001; in_data = {NCH{12'h777}};
    cyc(); chk("ar_pending", int'(out_valid), 1);
    in_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(out_valid), 0);
    chk("ar_data",  int'(out_data), 0);
    chk("ar_ovf",   int'(ovf_count), 0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    in_valid = 4'b0100; in_data = {NCH{12'h05A}};
    cyc(); chk("ar_ch2_ignored", int'(out_valid), 0);
    in_valid = 4'b0001;
    cyc(); chk("ar_ch0_valid", int'(out_valid), 1); chk("ar_ch0_data", int'(out_data), 'h05A);
    in_valid = '0;

    // Randomized run against the reference model.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_reset();
    for (int c = 0; c < 600; c++) begin
      frame_start = ($urandom_range(7) == 0);
      sel         = 2'($urandom_range(3));
      roll_mode   = 1'($urandom_range(1));
      decim       = 16'($urandom_range(5));
      in_valid    = 4'($urandom);
      for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = 12'($urandom);
      out_ready   = ($urandom_range(9) < 6);
      @(posedge clk);
      m_step();
      #1;
      chk("rnd_valid", int'(out_valid), m_v);
      if (m_v != 0) begin
        chk("rnd_data", int'(out_data), m_d);
        chk("rnd_ch",   int'(out_ch),   m_c);
      end
      chk("rnd_ovf", int'(ovf_count), m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
